dat_pacer_fifo: RTL and testbench
=================================

DAT_PACER_FIFO -- requirements
Module: dat_pacer_fifo

Upstream feeder for the test datapath. Buffers words from a valid/ready source and emits them as a paced vld/dat stream. The consumer has no backpressure.

Interface
REQ-001 Parameter DW, default 8, data word width in bits (tied to the system data width at instantiation).
REQ-002 Parameter DEPTH, default 16, FIFO depth in words; SHALL be a power of two and at least 2.
REQ-003 Parameter GAP, default 0, number of idle cycles forced between consecutive output words (range 0..255).
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 s_vld  input  1  source word valid.
REQ-007 s_dat  input  DW  source word.
REQ-008 s_rdy  output  1  FIFO can accept a word this cycle.
REQ-009 vld  output  1  output word valid, one-cycle pulse per word.
REQ-010 dat_o  output  DW  output word.
REQ-011 level  output  log2(DEPTH)+1  number of words currently stored.

Function
REQ-012 A write SHALL occur on a rising edge where s_vld=1 and s_rdy=1; s_dat is stored at the write pointer and the write pointer increments.
REQ-013 s_rdy SHALL be a registered output, equal to 1 when level<DEPTH and rst=0, and 0 otherwise.
- When full, s_rdy=0 regardless of any pop in the same cycle.
REQ-014 When s_vld=1 and s_rdy=0, the source SHALL hold s_dat stable; the block SHALL ignore the word with no loss or corruption.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow below 0.
REQ-016 Pacing counter gap_cnt (8 bit) behaviour on each edge:
- if level>0 and gap_cnt==0: pop one word, register it to dat_o, set vld=1, load gap_cnt with GAP;
- otherwise: vld=0, and gap_cnt decrements if it is non-zero.
REQ-017 dat_o SHALL hold its last popped value while vld=0.
REQ-018 Words SHALL be emitted in strict write order.
REQ-019 Latency: with gap_cnt=0 and level=0, a word written on edge E SHALL be popped on edge E+1, so vld=1 in the cycle after edge E+1.
REQ-020 Output spacing: consecutive vld pulses SHALL be exactly GAP+1 cycles apart while the FIFO stays non-empty.
- GAP=0 gives continuous vld.
REQ-021 Simultaneous write and pop on the same edge SHALL leave level unchanged; write alone adds +1, pop alone subtracts 1.
REQ-022 A pop on an edge SHALL depend only on level before that edge.
- A word written on the same edge as the FIFO becoming non-empty is not popped on that edge.

Reset
REQ-023 While rst=1 on an edge: read pointer, write pointer, level and gap_cnt SHALL clear to 0; vld=0; dat_o=0; s_rdy=0; no write or pop SHALL occur.
REQ-024 On the first edge with rst=0, s_rdy SHALL become 1.
REQ-025 Stored contents SHALL be discarded on reset.
- No word written before reset shall ever appear on vld/dat_o.
- The storage array itself need not be cleared.
REQ-026 A reset asserted mid-stream SHALL take effect on the next edge, overriding any write or pop on that edge.

Verification
REQ-027 Reset: rst=1 for 3 cycles with s_vld=1 -> the cycle after release shows vld=0, dat_o=0, level=0; s_rdy=0 during reset and 1 one edge after release.
REQ-028 Single word, GAP=0: write 0xA5 on edge E -> vld=1 and dat_o=0xA5 for exactly one cycle after edge E+1; dat_o stays 0xA5 afterwards; level returns to 0.
REQ-029 Backpressure, GAP=3, DEPTH=16: offer 0x00..0x17 (24 words) back-to-back ->
- s_rdy drops to 0 when level=16;
- all 24 words are emitted in order;
- vld pulses are exactly 4 cycles apart;
- no word is duplicated or lost.
REQ-030 Simultaneous push/pop, GAP=0: hold level=1 and write each cycle -> level stays 1 and vld stays high continuously with sequential data.
REQ-031 Mid-stream reset: at level=8, assert rst for 1 cycle -> level=0 and vld=0 after release; none of the 8 stale words ever appears; a new word 0x3C written next is emitted with the REQ-019 latency.
REQ-032 Wrap-around, DEPTH=16, GAP=0: stream 40 words with s_vld toggling every other cycle -> output order intact across at least two pointer wraps, and level never exceeds 1.

Source files
------------

// File: rtl/dat_pacer_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : dat_pacer_fifo_if
// Brief    : Source-side valid/ready and paced output bundle for dat_pacer_fifo.
// Revision : 1.0
// ============================================================================
interface dat_pacer_fifo_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
);
    localparam int c_lw = $clog2(DEPTH) + 1;

    logic            s_vld;
    logic [DW-1:0]   s_dat;
    logic            s_rdy;
    logic            vld;
    logic [DW-1:0]   dat_o;
    logic [c_lw-1:0] level;

    modport master (
        output s_vld, s_dat,
        input  s_rdy, vld, dat_o, level
    );

    modport slave (
        input  s_vld, s_dat,
        output s_rdy, vld, dat_o, level
    );
endinterface
`default_nettype wire

// File: rtl/dat_pacer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dat_pacer_fifo
// Brief    : FIFO fed by a valid/ready source, drained as a paced vld/dat stream.
// Revision : 1.0
// ============================================================================
module dat_pacer_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    dat_pacer_fifo_if.slave  bus
);
    localparam int             c_aw    = $clog2(DEPTH);
    localparam int             c_lw    = c_aw + 1;
    localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);
    localparam logic [c_lw-1:0] c_one   = c_lw'(1);
    localparam logic [7:0]      c_gap   = 8'(GAP);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_lw-1:0] r_level;
    logic [7:0]      r_gap_cnt;
    logic            r_rdy;
    logic            r_vld;
    logic [DW-1:0]   r_dat;

    logic            w_write;
    logic            w_pop;
    logic [c_lw-1:0] w_level_nxt;

    // Pop decision uses only the pre-edge level, so a word landing in an
    // empty FIFO is never popped on its own write edge.
    always_comb begin
        w_write     = bus.s_vld & r_rdy;
        w_pop       = (r_level != '0) && (r_gap_cnt == 8'd0);
        w_level_nxt = r_level;
        case ({w_write, w_pop})
            2'b10:   w_level_nxt = r_level + c_one;
            2'b01:   w_level_nxt = r_level - c_one;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage is not reset; pointers and level make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_mem[r_wr_ptr] <= bus.s_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_gap_cnt <= 8'd0;
            r_rdy     <= 1'b0;
            r_vld     <= 1'b0;
            r_dat     <= '0;
        end else begin
            r_level <= w_level_nxt;
            r_rdy   <= (w_level_nxt < c_depth);
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_dat     <= r_mem[r_rd_ptr];
                r_vld     <= 1'b1;
                r_gap_cnt <= c_gap;
            end else begin
                r_vld <= 1'b0;
                if (r_gap_cnt != 8'd0) begin
                    r_gap_cnt <= r_gap_cnt - 8'd1;
                end
            end
        end
    end

    assign bus.s_rdy = r_rdy;
    assign bus.vld   = r_vld;
    assign bus.dat_o = r_dat;
    assign bus.level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_dat_pacer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_dat_pacer_fifo
// Brief    : Directed self-checking bench; instance a has GAP=0, instance b GAP=3.
// Revision : 1.0
// ============================================================================
module tb_dat_pacer_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    dat_pacer_fifo_if #(.DW(8), .DEPTH(16)) a_if ();
    dat_pacer_fifo_if #(.DW(8), .DEPTH(16)) b_if ();

    dat_pacer_fifo #(.DW(8), .DEPTH(16), .GAP(0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    dat_pacer_fifo #(.DW(8), .DEPTH(16), .GAP(3)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.s_vld = 1'b1; a_if.s_dat = 8'h77;
        b_if.s_vld = 1'b1; b_if.s_dat = 8'h77;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (a_if.s_rdy !== 1'b0 || b_if.s_rdy !== 1'b0) begin
                failures++;
                $display("FAIL reset_rdy cyc=%0d a=%b b=%b expected 0", i, a_if.s_rdy, b_if.s_rdy);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (a_if.vld !== 1'b0 || a_if.dat_o !== 8'h00 || a_if.level !== 5'd0) begin
            failures++;
            $display("FAIL reset_state vld=%b dat=%h level=%0d expected 0/00/0", a_if.vld, a_if.dat_o, a_if.level);
        end
        checks++;
        if (a_if.s_rdy !== 1'b1 || b_if.s_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_rdy a=%b b=%b expected 1", a_if.s_rdy, b_if.s_rdy);
        end
        checks++;
        if (b_if.level !== 5'd0 || b_if.vld !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_b level=%0d vld=%b expected 0/0", b_if.level, b_if.vld);
        end
        a_if.s_vld = 1'b0;
        b_if.s_vld = 1'b0;
    endtask

    task automatic test_single_word();
        a_if.s_vld = 1'b1; a_if.s_dat = 8'hA5;
        tick();
        a_if.s_vld = 1'b0;
        checks++;
        if (a_if.level !== 5'd1 || a_if.vld !== 1'b0) begin
            failures++;
            $display("FAIL single_write level=%0d vld=%b expected 1/0", a_if.level, a_if.vld);
        end
        tick();
        checks++;
        if (a_if.vld !== 1'b1 || a_if.dat_o !== 8'hA5 || a_if.level !== 5'd0) begin
            failures++;
            $display("FAIL single_pop vld=%b dat=%h level=%0d expected 1/a5/0", a_if.vld, a_if.dat_o, a_if.level);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (a_if.vld !== 1'b0 || a_if.dat_o !== 8'hA5) begin
                failures++;
                $display("FAIL single_hold cyc=%0d vld=%b dat=%h expected 0/a5", i, a_if.vld, a_if.dat_o);
            end
        end
    endtask

    task automatic test_backpressure();
        int   nin = 0;
        int   nout = 0;
        int   last = 0;
        bit   saw_full = 1'b0;
        logic acc;
        for (int cyc = 1; cyc <= 300 && nout < 24; cyc++) begin
            b_if.s_vld = (nin < 24);
            b_if.s_dat = 8'(nin);
            acc = b_if.s_vld && b_if.s_rdy;
            tick();
            if (acc) nin++;
            if (b_if.level > 5'd16) begin
                checks++; failures++;
                $display("FAIL bp_level_max level=%0d expected <=16", b_if.level);
            end
            if (b_if.level == 5'd16) begin
                saw_full = 1'b1;
                checks++;
                if (b_if.s_rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full_rdy s_rdy=%b expected 0", b_if.s_rdy);
                end
            end
            if (b_if.vld === 1'b1) begin
                checks++;
                if (b_if.dat_o !== 8'(nout)) begin
                    failures++;
                    $display("FAIL bp_order dat=%h expected %h", b_if.dat_o, 8'(nout));
                end
                if (nout > 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        failures++;
                        $display("FAIL bp_spacing gap=%0d expected 4", cyc - last);
                    end
                end
                last = cyc;
                nout++;
            end
        end
        b_if.s_vld = 1'b0;
        checks++;
        if (nout != 24 || nin != 24) begin
            failures++;
            $display("FAIL bp_count out=%0d in=%0d expected 24/24", nout, nin);
        end
        checks++;
        if (!saw_full) begin
            failures++;
            $display("FAIL bp_saw_full got 0 expected 1");
        end
        checks++;
        if (b_if.level !== 5'd0) begin
            failures++;
            $display("FAIL bp_drain level=%0d expected 0", b_if.level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            a_if.s_vld = 1'b1;
            a_if.s_dat = 8'(16 + i);
            tick();
            checks++;
            if (i == 0) begin
                if (a_if.level !== 5'd1 || a_if.vld !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_first level=%0d vld=%b expected 1/0", a_if.level, a_if.vld);
                end
            end else if (a_if.level !== 5'd1 || a_if.vld !== 1'b1 || a_if.dat_o !== 8'(15 + i)) begin
                failures++;
                $display("FAIL b2b_steady i=%0d level=%0d vld=%b dat=%h expected 1/1/%h",
                         i, a_if.level, a_if.vld, a_if.dat_o, 8'(15 + i));
            end
        end
        a_if.s_vld = 1'b0;
        tick();
        checks++;
        if (a_if.level !== 5'd0 || a_if.vld !== 1'b1 || a_if.dat_o !== 8'h19) begin
            failures++;
            $display("FAIL b2b_last level=%0d vld=%b dat=%h expected 0/1/19", a_if.level, a_if.vld, a_if.dat_o);
        end
        tick();
        checks++;
        if (a_if.vld !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle vld=%b expected 0", a_if.vld);
        end
    endtask

    task automatic test_midstream_reset();
        int   nin = 0;
        logic acc;
        for (int i = 0; i < 40 && b_if.level != 5'd8; i++) begin
            b_if.s_vld = 1'b1;
            b_if.s_dat = 8'(224 + nin);
            acc = b_if.s_rdy;
            tick();
            if (acc) nin++;
        end
        b_if.s_vld = 1'b0;
        checks++;
        if (b_if.level !== 5'd8) begin
            failures++;
            $display("FAIL mid_fill level=%0d expected 8", b_if.level);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (b_if.level !== 5'd0 || b_if.vld !== 1'b0 || b_if.s_rdy !== 1'b0 || b_if.dat_o !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset level=%0d vld=%b rdy=%b dat=%h expected 0/0/0/00",
                     b_if.level, b_if.vld, b_if.s_rdy, b_if.dat_o);
        end
        tick();
        checks++;
        if (b_if.s_rdy !== 1'b1 || b_if.level !== 5'd0 || b_if.vld !== 1'b0) begin
            failures++;
            $display("FAIL mid_release rdy=%b level=%0d vld=%b expected 1/0/0", b_if.s_rdy, b_if.level, b_if.vld);
        end
        b_if.s_vld = 1'b1; b_if.s_dat = 8'h3C;
        tick();
        b_if.s_vld = 1'b0;
        checks++;
        if (b_if.level !== 5'd1 || b_if.vld !== 1'b0) begin
            failures++;
            $display("FAIL mid_new_write level=%0d vld=%b expected 1/0", b_if.level, b_if.vld);
        end
        tick();
        checks++;
        if (b_if.vld !== 1'b1 || b_if.dat_o !== 8'h3C) begin
            failures++;
            $display("FAIL mid_new_pop vld=%b dat=%h expected 1/3c", b_if.vld, b_if.dat_o);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (b_if.vld !== 1'b0 || b_if.dat_o !== 8'h3C) begin
                failures++;
                $display("FAIL mid_stale i=%0d vld=%b dat=%h expected 0/3c", i, b_if.vld, b_if.dat_o);
            end
        end
    endtask

    task automatic test_wrap();
        int   nin = 0;
        int   nout = 0;
        logic acc;
        for (int cyc = 0; cyc < 120 && nout < 40; cyc++) begin
            a_if.s_vld = ((cyc % 2) == 0) && (nin < 40);
            a_if.s_dat = 8'(64 + nin);
            acc = a_if.s_vld && a_if.s_rdy;
            tick();
            if (acc) nin++;
            checks++;
            if (a_if.level > 5'd1) begin
                failures++;
                $display("FAIL wrap_level level=%0d expected <=1", a_if.level);
            end
            if (a_if.vld === 1'b1) begin
                checks++;
                if (a_if.dat_o !== 8'(64 + nout)) begin
                    failures++;
                    $display("FAIL wrap_order dat=%h expected %h", a_if.dat_o, 8'(64 + nout));
                end
                nout++;
            end else if (nout > 0) begin
                checks++;
                if (a_if.dat_o !== 8'(63 + nout)) begin
                    failures++;
                    $display("FAIL wrap_hold dat=%h expected %h", a_if.dat_o, 8'(63 + nout));
                end
            end
        end
        a_if.s_vld = 1'b0;
        checks++;
        if (nout != 40) begin
            failures++;
            $display("FAIL wrap_count out=%0d expected 40", nout);
        end
    endtask

    initial begin
        a_if.s_vld = 1'b0; a_if.s_dat = 8'h00;
        b_if.s_vld = 1'b0; b_if.s_dat = 8'h00;
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_midstream_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
